// File: rtl/mem_fill_responder.sv
// mem_fill_responder
//   Backing store for a cache fill engine. A fill request returns the 8-word
//   (16-byte) block containing req_addr_i as 8 consecutive beats, the first
//   one LATENCY cycles after the request is accepted. Single-word writes are
//   accepted only while idle and take priority over fill requests.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset (array contents survive it)
//   req_valid_i  fill request            req_addr_i   byte address of the miss
//   req_ready_o  fill request accepted this cycle when req_valid_i=1
//   wr_en_i      write request           wr_addr_i / wr_data_i  word write
//   wr_ready_o   write accepted this cycle when wr_en_i=1
//   rsp_valid_o  fill beat valid         rsp_data_o   fill word
//   rsp_word_o   word index in block     rsp_last_o   word-7 beat
//   busy_o       fill in progress
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | accepting writes and fill requests
// S_ISSUE | one array read per cycle, words 0..7 in order
// S_DRAIN | reads done, waiting for the word-7 beat to leave the pipe

module mem_fill_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic [15:0] req_addr_i,
  output logic        req_ready_o,
  input  logic        wr_en_i,
  input  logic [15:0] wr_addr_i,
  input  logic [15:0] wr_data_i,
  output logic        wr_ready_o,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic [2:0]  rsp_word_o,
  output logic        rsp_last_o,
  output logic        busy_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] base_q, base_d;
  logic [2:0]  rd_cnt_q, rd_cnt_d;

  logic [15:0] mem_q [DEPTH];

  logic        pipe_vld_q  [LATENCY];
  logic [15:0] pipe_data_q [LATENCY];
  logic [2:0]  pipe_word_q [LATENCY];

  logic                  wr_accept;
  logic                  req_accept;
  logic                  rd_fire;
  logic                  out_last;
  logic [15:0]           rd_byte;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  unused_bits;

  // Block base is concatenated, never added, so word 7 of block 0xFFF0 cannot
  // carry into the next block.
  assign rd_byte = {base_q, rd_cnt_q, 1'b0};
  // Address bits above DEPTH_LOG2 are dropped: the array aliases.
  assign rd_idx  = rd_byte[DEPTH_LOG2:1];
  assign wr_idx  = wr_addr_i[DEPTH_LOG2:1];

  assign wr_accept  = wr_en_i & wr_ready_o;
  assign req_accept = req_valid_i & req_ready_o;
  assign rd_fire    = (state_q == S_ISSUE);
  assign out_last   = pipe_vld_q[LATENCY-1] & (pipe_word_q[LATENCY-1] == 3'd7);

  assign unused_bits = ^{req_addr_i[3:0], wr_addr_i, rd_byte};

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_accept) begin
          state_d  = S_ISSUE;
          base_d   = req_addr_i[15:4];
          rd_cnt_d = 3'd0;
        end
      end
      S_ISSUE: begin
        rd_cnt_d = rd_cnt_q + 3'd1;
        if (rd_cnt_q == 3'd7) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    wr_ready_o  = (state_q == S_IDLE);
    req_ready_o = (state_q == S_IDLE) & ~wr_en_i;
    busy_o      = (state_q != S_IDLE);
  end

  // Backing array: no reset so contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      mem_q[wr_idx] <= wr_data_i;
    end
  end

  // Read pipeline. Stage 0 captures the array read at the issue edge; each
  // further stage adds one cycle, so the output stage is LATENCY-1 cycles
  // behind the read and the first beat shows LATENCY cycles after accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_data_q[i] <= '0;
        pipe_word_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0]  <= rd_fire;
      pipe_data_q[0] <= mem_q[rd_idx];
      pipe_word_q[0] <= rd_cnt_q;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
        pipe_word_q[i] <= pipe_word_q[i-1];
      end
    end
  end

  // Payload is forced to zero whenever no beat is being presented.
  assign rsp_valid_o = pipe_vld_q[LATENCY-1];
  assign rsp_data_o  = pipe_vld_q[LATENCY-1] ? pipe_data_q[LATENCY-1] : 16'h0000;
  assign rsp_word_o  = pipe_vld_q[LATENCY-1] ? pipe_word_q[LATENCY-1] : 3'd0;
  assign rsp_last_o  = out_last;

endmodule

// File: tb/tb_mem_fill_responder.sv
// Bench for mem_fill_responder: three instances (LATENCY 4, 1, 8) share the
// write bus and request address; each has its own req_valid so a request can
// be held across a busy window independently.
module tb_mem_fill_responder;

  localparam int DL2   = 10;
  localparam int DEPTH = 1 << DL2;
  localparam int ND    = 3;
  localparam int FULL  = 33;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid_v [ND];
  logic [15:0] req_addr;
  logic        wr_en;
  logic [15:0] wr_addr, wr_data;
  logic        req_ready [ND];
  logic        wr_ready  [ND];
  logic        rsp_valid [ND];
  logic        rsp_last  [ND];
  logic        busy      [ND];
  logic [15:0] rsp_data  [ND];
  logic [2:0]  rsp_word  [ND];

  int checks   = 0;
  int failures = 0;

  logic [15:0] model [DEPTH];
  logic [15:0] cap   [ND][2][8];

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_w0;
    logic [15:0] exp_w7;
  } vec_t;
  vec_t tbl [$];

  mem_fill_responder #(.LATENCY(4), .DEPTH_LOG2(DL2)) u_dut_l4 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid_v[0]), .req_addr_i(req_addr),
    .req_ready_o(req_ready[0]), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_ready_o(wr_ready[0]), .rsp_valid_o(rsp_valid[0]), .rsp_data_o(rsp_data[0]),
    .rsp_word_o(rsp_word[0]), .rsp_last_o(rsp_last[0]), .busy_o(busy[0]));

  mem_fill_responder #(.LATENCY(1), .DEPTH_LOG2(DL2)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid_v[1]), .req_addr_i(req_addr),
    .req_ready_o(req_ready[1]), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_ready_o(wr_ready[1]), .rsp_valid_o(rsp_valid[1]), .rsp_data_o(rsp_data[1]),
    .rsp_word_o(rsp_word[1]), .rsp_last_o(rsp_last[1]), .busy_o(busy[1]));

  mem_fill_responder #(.LATENCY(8), .DEPTH_LOG2(DL2)) u_dut_l8 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid_v[2]), .req_addr_i(req_addr),
    .req_ready_o(req_ready[2]), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_ready_o(wr_ready[2]), .rsp_valid_o(rsp_valid[2]), .rsp_data_o(rsp_data[2]),
    .rsp_word_o(rsp_word[2]), .rsp_last_o(rsp_last[2]), .busy_o(busy[2]));

  function automatic int lat_of(int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  // Word j of the block holding addr, straight from the address arithmetic.
  function automatic logic [15:0] model_word(logic [15:0] addr, int j);
    int base;
    int byte_a;
    base   = int'(addr) & 'hFFF0;
    byte_a = base + 2 * j;
    return model[(byte_a / 2) % DEPTH];
  endfunction

  // {valid, last, word, data, busy, req_ready, wr_ready}
  function automatic logic [23:0] obs(int d);
    return {rsp_valid[d], rsp_last[d], rsp_word[d], rsp_data[d], busy[d], req_ready[d], wr_ready[d]};
  endfunction

  task automatic check(string name, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lat=%0d t=%0t got=%h expected=%h", name, lat_of(d), $time, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy[0] | busy[1] | busy[2]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout got=busy expected=idle");
    end
  endtask

  // Entered and left at a negedge with all instances idle.
  task automatic do_write(logic [15:0] a, logic [15:0] dt, bit also_req, logic [15:0] ra);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = dt;
    if (also_req) begin
      req_addr = ra;
      for (int d = 0; d < ND; d++) req_valid_v[d] = 1'b1;
    end
    #1;
    for (int d = 0; d < ND; d++) check("wr_accept_rdy", d, {30'd0, wr_ready[d], req_ready[d]}, 32'd2);
    @(negedge clk);
    wr_en = 1'b0;
    model[(int'(a) / 2) % DEPTH] = dt;
  endtask

  // Fill a0; if chained, a1 is requested during the fill and held until taken.
  // Window k is the cycle after accept edge T0+k.
  task automatic run_fill(logic [15:0] a0, logic [15:0] a1, bit chained, int stop_k);
    for (int d = 0; d < ND; d++)
      for (int f = 0; f < 2; f++)
        for (int j = 0; j < 8; j++) cap[d][f][j] = 'x;
    req_addr = a0;
    for (int d = 0; d < ND; d++) req_valid_v[d] = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) check("req_accept_rdy", d, {31'd0, req_ready[d]}, 32'd1);
    for (int k = 0; k <= stop_k; k++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        int          lat;
        int          acc [2];
        logic        ev, el, eb;
        logic [2:0]  ew;
        logic [15:0] ed;
        lat = lat_of(d);
        acc[0] = 0;
        acc[1] = lat + 9;
        ev = 1'b0; el = 1'b0; eb = 1'b0; ew = 3'd0; ed = 16'h0000;
        for (int f = 0; f < (chained ? 2 : 1); f++) begin
          if (k >= acc[f] && k <= acc[f] + lat + 7) eb = 1'b1;
          if (k >= acc[f] + lat && k <= acc[f] + lat + 7) begin
            int j;
            j  = k - acc[f] - lat;
            ev = 1'b1;
            ew = 3'(j);
            el = (j == 7);
            ed = model_word(f == 0 ? a0 : a1, j);
            cap[d][f][j] = rsp_data[d];
          end
        end
        check("fill_window", d, {8'd0, obs(d)}, {8'd0, ev, el, ew, ed, eb, ~eb, ~eb});
        req_valid_v[d] = chained && (k <= lat + 8);
      end
      if (k == 0) req_addr = a1;
    end
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    req_addr = '0;
    for (int d = 0; d < ND; d++) req_valid_v[d] = 1'b0;

    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b1, 16'h0040 + 16'(2 * i), 16'h1000 + 16'(i), 16'h0, 16'h0});
    tbl.push_back('{1'b0, 16'h0046, 16'h0, 16'h1000, 16'h1007});
    tbl.push_back('{1'b0, 16'h0100, 16'h0, 16'hC080, 16'hC087});
    tbl.push_back('{1'b0, 16'hFFF0, 16'h0, 16'hC3F8, 16'hC3FF});
    tbl.push_back('{1'b0, 16'h07F0, 16'h0, 16'hC3F8, 16'hC3FF});
    tbl.push_back('{1'b1, 16'h0800, 16'h1234, 16'h0, 16'h0});
    tbl.push_back('{1'b0, 16'h0000, 16'h0, 16'h1234, 16'hC007});

    // Reset state
    @(negedge clk);
    for (int d = 0; d < ND; d++) check("reset_state", d, {8'd0, obs(d)}, 32'h3);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < ND; d++) check("post_reset_ready", d, {8'd0, obs(d)}, 32'h3);

    // Preload every word so no read returns uninitialised data.
    for (int i = 0; i < DEPTH; i++) do_write(16'(2 * i), 16'hC000 + 16'(i), 1'b0, 16'h0);

    // Directed table
    foreach (tbl[t]) begin
      wait_idle();
      if (tbl[t].is_wr) begin
        do_write(tbl[t].addr, tbl[t].data, 1'b0, 16'h0);
      end else begin
        run_fill(tbl[t].addr, 16'h0, 1'b0, FULL);
        for (int d = 0; d < ND; d++) begin
          check("tbl_word0", d, {16'd0, cap[d][0][0]}, {16'd0, tbl[t].exp_w0});
          check("tbl_word7", d, {16'd0, cap[d][0][7]}, {16'd0, tbl[t].exp_w7});
        end
      end
    end

    // Write and fill request in the same cycle: write wins, then fill sees it.
    wait_idle();
    do_write(16'h0042, 16'hBEEF, 1'b1, 16'h0040);
    run_fill(16'h0040, 16'h0, 1'b0, FULL);
    for (int d = 0; d < ND; d++) check("wr_then_fill_beat1", d, {16'd0, cap[d][0][1]}, 32'hBEEF);

    // Request held while busy is taken the cycle after the last beat.
    wait_idle();
    run_fill(16'h0040, 16'h0100, 1'b1, FULL);
    for (int d = 0; d < ND; d++) begin
      check("chained_w0", d, {16'd0, cap[d][1][0]}, 32'hC080);
      check("chained_w7", d, {16'd0, cap[d][1][7]}, 32'hC087);
    end

    // Reset mid-fill aborts it.
    wait_idle();
    run_fill(16'h0100, 16'h0, 1'b0, 6);
    rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) check("rst_async", d, {8'd0, obs(d)}, 32'h3);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) check("post_abort_quiet", d, {8'd0, obs(d)}, 32'h3);
    end
    run_fill(16'h0046, 16'h0, 1'b0, FULL);
    for (int d = 0; d < ND; d++) begin
      check("after_abort_w0", d, {16'd0, cap[d][0][0]}, 32'h1000);
      check("after_abort_w7", d, {16'd0, cap[d][0][7]}, 32'h1007);
    end

    // Random mix against the model
    for (int it = 0; it < 40; it++) begin
      int sel;
      wait_idle();
      sel = $urandom_range(0, 2);
      if (sel == 0)
        do_write(16'($urandom), 16'($urandom), 1'b0, 16'h0);
      else if (sel == 1)
        run_fill(16'($urandom), 16'h0, 1'b0, FULL);
      else
        run_fill(16'($urandom), 16'($urandom), 1'b1, FULL);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_fill_responder.md
MEM_FILL_RESPONDER -- requirements
Module: mem_fill_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from request accept to first data word (range 1..8).
REQ-002 SHALL have parameter DEPTH_LOG2, default 10: log2 of the number of 16-bit words in the backing array.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  block-fill request from the cache fill FSM.
REQ-006 req_addr  input  16  byte address of the missing access.
REQ-007 req_ready  output  1  request is accepted this cycle when req_valid=1.
REQ-008 wr_en  input  1  single-word write-through request.
REQ-009 wr_addr  input  16  byte address of the write.
REQ-010 wr_data  input  16  write data.
REQ-011 wr_ready  output  1  write is accepted this cycle when wr_en=1.
REQ-012 rsp_valid  output  1  rsp_data holds a valid fill word.
REQ-013 rsp_data  output  16  fill word.
REQ-014 rsp_word  output  3  index of the word within the block (0..7).
REQ-015 rsp_last  output  1  high with the word-7 beat.
REQ-016 busy  output  1  fill in progress.

Function
REQ-017 Block = 8 words = 16 bytes; base = {req_addr[15:4], 4'h0}; word i byte address = base + 2*i; array index = address[DEPTH_LOG2:1]; address bits above DEPTH_LOG2 SHALL be ignored (aliasing).
REQ-018 States SHALL be IDLE, ISSUE, DRAIN.
REQ-019 wr_ready SHALL equal (state==IDLE); req_ready SHALL equal (state==IDLE) & ~wr_en (write has priority).
REQ-020 Accepted write SHALL commit to the array at the accepting edge; a later fill SHALL return the new value.
REQ-021 IDLE->ISSUE on request accept edge T0; base SHALL be latched at T0.
REQ-022 ISSUE SHALL issue one array read per cycle, words 0..7 in order, at edges T0+1..T0+8, then go to DRAIN.
REQ-023 Reads SHALL pass through a LATENCY-deep valid/data/index pipeline. Word i SHALL be presented (rsp_valid=1) in the cycle after edge T0+LATENCY+i. The 8 beats SHALL be consecutive with no gaps.
REQ-024 DRAIN->IDLE at the edge that retires the word-7 beat; a new request MAY be accepted in the following cycle.
REQ-025 busy SHALL be high from the cycle after T0 through the word-7 beat inclusive.
REQ-026 When rsp_valid=0, rsp_data, rsp_word and rsp_last SHALL be 0.
REQ-027 wr_en or req_valid asserted while busy SHALL be ignored (not ready); requesters SHALL hold their request until ready.
REQ-028 Block at 0xFFF0 SHALL return words 0xFFF0..0xFFFE with no carry into other blocks.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, clear all pipeline valid bits, and drive busy=0, rsp_valid=0, rsp_data=0, rsp_word=0, rsp_last=0.
REQ-030 Reset mid-fill SHALL abort the fill; no further beats of that block SHALL appear after rst deasserts.
REQ-031 Array contents SHALL NOT be altered by reset.
REQ-032 req_ready and wr_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-033 Preload word at 0x0040+2i = 0x1000+i; request 0x0046 at T0 -> beats at T0+4..T0+11 carry 0x1000..0x1007, rsp_word 0..7, rsp_last only on the last beat.
REQ-034 Write 0xBEEF to 0x0042 and assert req_valid in the same cycle -> write accepted, req_ready=0; then fill of 0x0040 -> beat 1 = 0xBEEF.
REQ-035 Assert req_valid at 0x0100 while busy -> ignored until IDLE; accepted the cycle after rsp_last; second block follows with no overlap.
REQ-036 Assert rst after beat 2 of a fill -> rsp_valid=0 and busy=0 at once; no further beats; next request returns the correct full block.
REQ-037 LATENCY=1 and LATENCY=8 builds; fill of 0xFFF0 -> first beat exactly LATENCY cycles after accept; data from 0xFFF0..0xFFFE aliased into the array.
